ssd_scan_scheduler: RTL and testbench

Time-multiplexing scheduler for the Nexys4 DDR eight-digit seven-segment display. It holds an 8 × 4-bit digit buffer. Two independent requesters write that buffer through a round-robin arbiter with a req/grant handshake. A prescaled scan sequencer walks the eight anodes, inserting a blanking interval at the start of each digit slot to suppress ghosting. The 4-bit `ssdNumber` output feeds the existing `sevenSegmentDecoder`; `ssdAnode` drives the board anodes directly.

---
 rtl/ssd_scan_scheduler.sv | 122 ++++++++++++
 tb/tb_ssd_scan_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler
//   Scan scheduler for the Nexys4 DDR eight-digit seven-segment display.
//   Holds an 8 x 4-bit digit buffer that two requesters write through a
//   round-robin arbiter. A prescaled sequencer walks the eight anodes and
//   blanks the first BLANK_CYCLES of every digit slot to suppress ghosting.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (< SCAN_DIV)
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-low
//   enable            1 = scan runs; 0 = scan frozen, display blanked
//   digitMask[7:0]    bit i = 1 shows digit i
//   reqA/addrA/dataA  write request, digit index and code from requester A
//   reqB/addrB/dataB  same for requester B
//   grantA/grantB     one-cycle acknowledge of a committed write
//   ssdNumber[3:0]    code of the active digit, to sevenSegmentDecoder
//   ssdAnode[7:0]     active-low anodes, at most one bit low
module ssd_scan_scheduler #(
    parameter int unsigned SCAN_DIV     = 50_000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] digitMask,
    input  logic       reqA,
    input  logic [2:0] addrA,
    input  logic [3:0] dataA,
    input  logic       reqB,
    input  logic [2:0] addrB,
    input  logic [3:0] dataB,
    output logic       grantA,
    output logic       grantB,
    output logic [3:0] ssdNumber,
    output logic [7:0] ssdAnode
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_SHOW
    } slot_t;

    typedef enum logic {
        LAST_A,
        LAST_B
    } last_t;

    logic [3:0]       buffer [8];
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dig;
    last_t            last;
    slot_t            slot;

    logic eligA;
    logic eligB;
    logic winA;
    logic winB;

    always_comb begin
        slot = (cnt < CNT_W'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_SHOW;
    end

    // A requester still seeing its acknowledge is not eligible, so a held
    // request cannot commit twice for one handshake.
    always_comb begin
        eligA = reqA && !grantA;
        eligB = reqB && !grantB;
        winA  = eligA && (!eligB || (last == LAST_B));
        winB  = eligB && !winA;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                buffer[i] <= 4'hF;
            end
            ssdNumber <= 4'hF;
            ssdAnode  <= 8'hFF;
            grantA    <= 1'b0;
            grantB    <= 1'b0;
            cnt       <= '0;
            dig       <= '0;
            last      <= LAST_B;
        end else begin
            // Scan sequencer
            if (enable) begin
                if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                    cnt <= '0;
                    dig <= dig + 3'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Outputs reflect the current cnt/dig, so they lag by one cycle.
            // ssdNumber reads the buffer before this edge's write lands.
            if (!enable || (slot == SLOT_BLANK) || !digitMask[dig]) begin
                ssdAnode <= 8'hFF;
            end else begin
                ssdAnode <= ~(8'b1 << dig);
            end
            ssdNumber <= buffer[dig];

            // Arbiter: at most one buffer write per edge
            grantA <= winA;
            grantB <= winB;
            if (winA) begin
                buffer[addrA] <= dataA;
                last          <= LAST_A;
            end else if (winB) begin
                buffer[addrB] <= dataB;
                last          <= LAST_B;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// tb_ssd_scan_scheduler
//   Directed bench for ssd_scan_scheduler with SCAN_DIV=10, BLANK_CYCLES=2.
//   Expected display samples and grants are queued with the cycle they
//   belong to; a negedge monitor pops and compares them.
module tb_ssd_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] digitMask;
    logic       reqA;
    logic [2:0] addrA;
    logic [3:0] dataA;
    logic       reqB;
    logic [2:0] addrB;
    logic [3:0] dataB;
    logic       grantA;
    logic       grantB;
    logic [3:0] ssdNumber;
    logic [7:0] ssdAnode;

    ssd_scan_scheduler #(
        .SCAN_DIV(10),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .digitMask(digitMask),
        .reqA(reqA),
        .addrA(addrA),
        .dataA(dataA),
        .reqB(reqB),
        .addrB(addrB),
        .dataB(dataB),
        .grantA(grantA),
        .grantB(grantB),
        .ssdNumber(ssdNumber),
        .ssdAnode(ssdAnode)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    typedef struct {
        int         cyc;
        logic [7:0] anode;
        logic [3:0] num;
    } scan_t;

    typedef struct {
        int         cyc;
        logic [1:0] g;   // {grantA, grantB}
    } grant_t;

    scan_t  sq [$];
    grant_t gq [$];

    int vectors    = 0;
    int miscompares = 0;
    int T0 = 0;
    int T1 = 0;

    task automatic push_scan(input int c, input logic [7:0] a, input logic [3:0] n);
        scan_t e;
        e.cyc = c; e.anode = a; e.num = n;
        sq.push_back(e);
    endtask

    task automatic push_grant(input int c, input logic [1:0] g);
        grant_t e;
        e.cyc = c; e.g = g;
        gq.push_back(e);
    endtask

    // Advance to posedge+1 of absolute cycle t
    task automatic at(input int t);
        while (tick < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        vectors++;
        if ($countones(~ssdAnode) > 1) begin
            miscompares++;
            $display("FAIL onehot tick=%0d ssdAnode=%h (at most one low bit allowed)", tick, ssdAnode);
        end
        if (grantA || grantB) begin
            vectors++;
            if (gq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_grant tick=%0d grantA=%b grantB=%b expected none", tick, grantA, grantB);
            end else begin
                grant_t e;
                e = gq.pop_front();
                if ({grantA, grantB} != e.g || tick != e.cyc) begin
                    miscompares++;
                    $display("FAIL grant tick=%0d got {A,B}=%b expected %b at tick %0d",
                             tick, {grantA, grantB}, e.g, e.cyc);
                end
            end
        end
        while (sq.size() > 0 && sq[0].cyc <= tick) begin
            scan_t e;
            e = sq.pop_front();
            vectors++;
            if (e.cyc < tick) begin
                miscompares++;
                $display("FAIL scan_missed expected sample at tick %0d, now %0d", e.cyc, tick);
            end else if (ssdAnode !== e.anode || ssdNumber !== e.num) begin
                miscompares++;
                $display("FAIL scan tick=%0d (rel T0 %0d) anode=%h num=%h expected anode=%h num=%h",
                         tick, tick - T0, ssdAnode, ssdNumber, e.anode, e.num);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        digitMask = 8'hFF;
        reqA = 1'b1; addrA = 3'd4; dataA = 4'h2;   // held during reset: must be dropped
        reqB = 1'b0; addrB = 3'd0; dataB = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reqA = 1'b0;
        reset = 1'b1;
        T0 = tick;

        // Scan after reset / single write / masking / freeze / contention / reset
        push_scan(T0 + 0,   8'hFF, 4'hF);
        push_scan(T0 + 1,   8'hFF, 4'hF);
        push_scan(T0 + 2,   8'hFF, 4'hF);
        push_scan(T0 + 3,   8'hFE, 4'hF);
        push_scan(T0 + 10,  8'hFE, 4'hF);
        push_scan(T0 + 11,  8'hFF, 4'hF);
        push_scan(T0 + 12,  8'hFF, 4'hF);
        push_scan(T0 + 13,  8'hFD, 4'hF);
        push_scan(T0 + 21,  8'hFF, 4'hF);
        push_scan(T0 + 31,  8'hFF, 4'h7);
        push_scan(T0 + 33,  8'hF7, 4'h7);
        push_scan(T0 + 40,  8'hF7, 4'h7);
        push_scan(T0 + 41,  8'hFF, 4'hF);
        push_scan(T0 + 79,  8'h7F, 4'hF);
        push_scan(T0 + 80,  8'h7F, 4'hF);
        push_scan(T0 + 81,  8'hFF, 4'hF);
        push_scan(T0 + 82,  8'hFF, 4'hF);
        push_scan(T0 + 83,  8'hFE, 4'hF);
        push_scan(T0 + 103, 8'hFB, 4'hF);
        push_scan(T0 + 110, 8'hFB, 4'hF);
        push_scan(T0 + 111, 8'hFF, 4'h7);
        push_scan(T0 + 113, 8'hFF, 4'h7);
        push_scan(T0 + 120, 8'hFF, 4'h7);
        push_scan(T0 + 121, 8'hFF, 4'hF);
        push_scan(T0 + 123, 8'hEF, 4'hF);
        push_scan(T0 + 185, 8'hFB, 4'hF);
        push_scan(T0 + 186, 8'hFF, 4'hF);
        push_scan(T0 + 191, 8'hFF, 4'hF);
        push_scan(T0 + 192, 8'hFF, 4'h9);
        push_scan(T0 + 205, 8'hFF, 4'h9);
        push_scan(T0 + 206, 8'hFB, 4'h9);
        push_scan(T0 + 210, 8'hFB, 4'h9);
        push_scan(T0 + 211, 8'hFF, 4'h7);
        push_scan(T0 + 213, 8'hF7, 4'h7);
        push_scan(T0 + 231, 8'hFF, 4'h3);
        push_scan(T0 + 233, 8'hDF, 4'h3);
        push_scan(T0 + 240, 8'hDF, 4'h3);
        push_scan(T0 + 241, 8'hFF, 4'h4);
        push_scan(T0 + 243, 8'hBF, 4'h4);
        push_scan(T0 + 250, 8'hBF, 4'h4);
        push_scan(T0 + 251, 8'hFF, 4'hF);
        push_scan(T0 + 252, 8'hFF, 4'hF);

        push_grant(T0 + 6,   2'b10);
        push_grant(T0 + 191, 2'b01);
        push_grant(T0 + 221, 2'b10);
        push_grant(T0 + 222, 2'b01);
        push_grant(T0 + 223, 2'b10);
        push_grant(T0 + 224, 2'b01);

        // Single write from A
        at(T0 + 5);   reqA = 1'b1; addrA = 3'd3; dataA = 4'h7;
        at(T0 + 7);   reqA = 1'b0;

        // Mask digit 3 for the whole second frame's digit-3 slot
        at(T0 + 90);  digitMask = 8'b1111_0111;
        at(T0 + 140); digitMask = 8'hFF;

        // Freeze at cnt=5 of digit 2, with a B write during the freeze
        at(T0 + 185); enable = 1'b0;
        at(T0 + 190); reqB = 1'b1; addrB = 3'd2; dataB = 4'h9;
        at(T0 + 192); reqB = 1'b0;
        at(T0 + 205); enable = 1'b1;

        // Contention: both held, new data presented after each grant
        at(T0 + 220); reqA = 1'b1; addrA = 3'd5; dataA = 4'h1;
                      reqB = 1'b1; addrB = 3'd6; dataB = 4'h2;
        at(T0 + 221); dataA = 4'h3;
        at(T0 + 222); dataB = 4'h4;
        at(T0 + 224); reqA = 1'b0; reqB = 1'b0;

        // Reset mid-operation with B requesting
        at(T0 + 250); reset = 1'b0; reqB = 1'b1; addrB = 3'd1; dataB = 4'h6;
        at(T0 + 253);
        reset = 1'b1;
        reqA = 1'b1; addrA = 3'd0; dataA = 4'h8;
        T1 = tick;

        push_scan(T1 + 0,  8'hFF, 4'hF);
        push_scan(T1 + 1,  8'hFF, 4'hF);
        push_scan(T1 + 2,  8'hFF, 4'h8);
        push_scan(T1 + 3,  8'hFE, 4'h8);
        push_scan(T1 + 13, 8'hFD, 4'h6);
        push_scan(T1 + 33, 8'hF7, 4'hF);
        push_scan(T1 + 53, 8'hDF, 4'hF);
        push_grant(T1 + 1, 2'b10);
        push_grant(T1 + 2, 2'b01);

        at(T1 + 2); reqA = 1'b0;
        at(T1 + 3); reqB = 1'b0;

        at(T1 + 60);
        @(negedge clk);
        #1;
        while (sq.size() > 0) begin
            scan_t e;
            e = sq.pop_front();
            miscompares++;
            $display("FAIL scan_pending sample for tick %0d never compared", e.cyc);
        end
        while (gq.size() > 0) begin
            grant_t e;
            e = gq.pop_front();
            miscompares++;
            $display("FAIL grant_missing expected {A,B}=%b at tick %0d, got none", e.g, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
